// File: rtl/lsnn_pkg.sv
// Shared constants and helpers for the LSNN neuron array: default parameters,
// index/refractory width derivation and a width-generic saturating add.
package lsnn_pkg;

  localparam int unsigned DEF_N_NEURONS         = 4;
  localparam int unsigned DEF_W                 = 8;
  localparam int unsigned DEF_LEAK_SHIFT        = 1;
  localparam int unsigned DEF_B0                = 8;
  localparam int unsigned DEF_A_INIT            = 8;
  localparam int unsigned DEF_ALPHA_INC         = 2;
  localparam int unsigned DEF_ADAPT_DECAY_SHIFT = 2;
  localparam int unsigned DEF_REFRACT           = 2;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned ref_width(input int unsigned r);
    return (r == 0) ? 1 : $clog2(r + 1);
  endfunction

  // Unsigned add clamped at 2^w-1; callers truncate the result to w bits.
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input int unsigned w);
    logic [32:0] sum;
    logic [32:0] max;
    sum = {1'b0, a} + {1'b0, b};
    max = (33'd1 << w) - 33'd1;
    return 32'((sum > max) ? max : sum);
  endfunction

endpackage

// File: rtl/lsnn_array_if.sv
// Stream interface of the LSNN array: current beats in, per-neuron spike
// results out, plus the per-step spike vector.
interface lsnn_array_if
  import lsnn_pkg::*;
#(
  parameter int unsigned N_NEURONS = DEF_N_NEURONS,
  parameter int unsigned W         = DEF_W,
  parameter int unsigned IDXW      = idx_width(N_NEURONS)
);
  logic                 in_valid;
  logic                 in_ready;
  logic [W-1:0]         in_current;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_spike;
  logic [IDXW-1:0]      out_idx;
  logic                 out_last;
  logic [W-1:0]         out_thr;
  logic [N_NEURONS-1:0] spike_vec;
  logic                 spike_vec_valid;

  modport master (
    output in_valid, in_current, out_ready,
    input  in_ready, out_valid, out_spike, out_idx, out_last, out_thr,
           spike_vec, spike_vec_valid
  );

  modport slave (
    input  in_valid, in_current, out_ready,
    output in_ready, out_valid, out_spike, out_idx, out_last, out_thr,
           spike_vec, spike_vec_valid
  );
endinterface

// File: rtl/lsnn_neuron_update.sv
// Combinational single-neuron LSNN step: leak, integrate, adaptive threshold,
// refractory handling. Shared by all neurons of the array through an index mux.
module lsnn_neuron_update
  import lsnn_pkg::*;
#(
  parameter int unsigned W                 = DEF_W,
  parameter int unsigned LEAK_SHIFT        = DEF_LEAK_SHIFT,
  parameter int unsigned B0                = DEF_B0,
  parameter int unsigned ALPHA_INC         = DEF_ALPHA_INC,
  parameter int unsigned ADAPT_DECAY_SHIFT = DEF_ADAPT_DECAY_SHIFT,
  parameter int unsigned REFRACT           = DEF_REFRACT,
  parameter int unsigned RW                = ref_width(REFRACT)
) (
  input  logic [W-1:0]  x,
  input  logic [W-1:0]  v,
  input  logic [W-1:0]  a,
  input  logic [RW-1:0] ref_cnt,
  output logic [W-1:0]  v_next,
  output logic [W-1:0]  a_next,
  output logic [RW-1:0] ref_next,
  output logic          spike,
  output logic [W-1:0]  thr
);
  logic [W-1:0] v_dec;
  logic [W-1:0] a_dec;
  logic [W-1:0] v_int;

  always_comb begin
    v_dec    = v - (v >> LEAK_SHIFT);
    a_dec    = a - (a >> ADAPT_DECAY_SHIFT);
    thr      = W'(sat_add(32'(B0), 32'(a), W));
    v_int    = W'(sat_add(32'(x), 32'(v_dec), W));
    spike    = 1'b0;
    v_next   = v_dec;
    a_next   = a_dec;
    ref_next = ref_cnt;
    if (ref_cnt != '0) begin
      ref_next = ref_cnt - RW'(1);
    end else if (v_int >= thr) begin
      spike    = 1'b1;
      v_next   = '0;
      ref_next = RW'(REFRACT);
      a_next   = W'(sat_add(32'(a), 32'(ALPHA_INC), W));
    end else begin
      v_next   = v_int;
    end
  end
endmodule

// File: rtl/lsnn_array.sv
// Time-multiplexed array of adaptive-threshold LIF neurons: one neuron updated
// per accepted beat, one registered result per beat, spike vector per step.
module lsnn_array
  import lsnn_pkg::*;
#(
  parameter int unsigned N_NEURONS         = DEF_N_NEURONS,
  parameter int unsigned W                 = DEF_W,
  parameter int unsigned LEAK_SHIFT        = DEF_LEAK_SHIFT,
  parameter int unsigned B0                = DEF_B0,
  parameter int unsigned A_INIT            = DEF_A_INIT,
  parameter int unsigned ALPHA_INC         = DEF_ALPHA_INC,
  parameter int unsigned ADAPT_DECAY_SHIFT = DEF_ADAPT_DECAY_SHIFT,
  parameter int unsigned REFRACT           = DEF_REFRACT
) (
  input logic         clk,
  input logic         rst_n,
  input logic         clear,
  lsnn_array_if.slave bus
);
  localparam int unsigned IDXW = idx_width(N_NEURONS);
  localparam int unsigned RW   = ref_width(REFRACT);

  logic [W-1:0]         v_mem [N_NEURONS];
  logic [W-1:0]         a_mem [N_NEURONS];
  logic [RW-1:0]        r_mem [N_NEURONS];
  logic [IDXW-1:0]      idx;
  logic [N_NEURONS-1:0] shadow;
  logic [N_NEURONS-1:0] step_vec;

  logic                 out_valid_q, out_spike_q, out_last_q;
  logic [IDXW-1:0]      out_idx_q;
  logic [W-1:0]         out_thr_q;
  logic [N_NEURONS-1:0] spike_vec_q;
  logic                 spike_vec_valid_q;

  logic [W-1:0]  nu_v_next, nu_a_next, nu_thr;
  logic [RW-1:0] nu_ref_next;
  logic          nu_spike;
  logic          in_ready, accept, is_last;

  lsnn_neuron_update #(
    .W                 (W),
    .LEAK_SHIFT        (LEAK_SHIFT),
    .B0                (B0),
    .ALPHA_INC         (ALPHA_INC),
    .ADAPT_DECAY_SHIFT (ADAPT_DECAY_SHIFT),
    .REFRACT           (REFRACT),
    .RW                (RW)
  ) u_update (
    .x        (bus.in_current),
    .v        (v_mem[idx]),
    .a        (a_mem[idx]),
    .ref_cnt  (r_mem[idx]),
    .v_next   (nu_v_next),
    .a_next   (nu_a_next),
    .ref_next (nu_ref_next),
    .spike    (nu_spike),
    .thr      (nu_thr)
  );

  assign in_ready = !clear && (!out_valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;
  assign is_last  = (idx == IDXW'(N_NEURONS - 1));

  // Step vector including the neuron being updated, so the last bit lands in
  // spike_vec on the same edge that completes the step.
  always_comb begin
    step_vec      = shadow;
    step_vec[idx] = nu_spike;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < N_NEURONS; k++) begin
        v_mem[k] <= '0;
        a_mem[k] <= W'(A_INIT);
        r_mem[k] <= '0;
      end
      idx               <= '0;
      shadow            <= '0;
      spike_vec_q       <= '0;
      spike_vec_valid_q <= 1'b0;
      out_valid_q       <= 1'b0;
      out_spike_q       <= 1'b0;
      out_idx_q         <= '0;
      out_last_q        <= 1'b0;
      out_thr_q         <= '0;
    end else if (clear) begin
      for (int unsigned k = 0; k < N_NEURONS; k++) begin
        v_mem[k] <= '0;
        a_mem[k] <= W'(A_INIT);
        r_mem[k] <= '0;
      end
      idx               <= '0;
      shadow            <= '0;
      spike_vec_valid_q <= 1'b0;
      out_valid_q       <= 1'b0;
    end else begin
      spike_vec_valid_q <= 1'b0;
      if (accept) begin
        v_mem[idx]  <= nu_v_next;
        a_mem[idx]  <= nu_a_next;
        r_mem[idx]  <= nu_ref_next;
        out_valid_q <= 1'b1;
        out_spike_q <= nu_spike;
        out_idx_q   <= idx;
        out_last_q  <= is_last;
        out_thr_q   <= nu_thr;
        if (is_last) begin
          spike_vec_q       <= step_vec;
          spike_vec_valid_q <= 1'b1;
          shadow            <= '0;
          idx               <= '0;
        end else begin
          shadow <= step_vec;
          idx    <= idx + IDXW'(1);
        end
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready        = in_ready;
  assign bus.out_valid       = out_valid_q;
  assign bus.out_spike       = out_spike_q;
  assign bus.out_idx         = out_idx_q;
  assign bus.out_last        = out_last_q;
  assign bus.out_thr         = out_thr_q;
  assign bus.spike_vec       = spike_vec_q;
  assign bus.spike_vec_valid = spike_vec_valid_q;
endmodule
